// File: rtl/mod_74x191_clr.sv
// Presettable up/down binary counter in the style of the 74x191, with an
// added asynchronous active-low clear and the terminal-count/ripple outputs.
module mod_74x191_clr #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             CTEN_N,
  input  logic             D_U,
  input  logic             LOAD_N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             MAX_MIN,
  output logic             RCO_N
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;

  // Clear overrides everything; load beats count; natural wrap modulo 2^WIDTH.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      Q <= ZERO;
    end else if (!LOAD_N) begin
      Q <= D;
    end else if (!CTEN_N) begin
      if (D_U) begin
        Q <= Q - ONE;
      end else begin
        Q <= Q + ONE;
      end
    end
  end

  // RCO_N is gated by the low clock phase so its rising edge lines up with
  // this stage's next rising edge, which clocks the following stage.
  always_comb begin
    MAX_MIN = D_U ? (Q == ZERO) : (Q == ALL_ONE);
    RCO_N   = ~(MAX_MIN & ~CLK & ~CTEN_N);
  end

endmodule

// File: tb/tb_mod_74x191_clr.sv
// Directed self-checking bench for mod_74x191_clr, including a two-stage
// cascade where the second stage is clocked by the first stage's RCO_N.
module tb_mod_74x191_clr;

  logic       clk = 1'b0;
  logic       clr_n, cten_n, d_u, load_n;
  logic [3:0] d;
  logic [3:0] q;
  logic       max_min, rco_n;

  logic       c_clr_n;
  logic [3:0] q1, q2;
  logic       max1, rco1, max2, rco2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_74x191_clr #(.WIDTH(4)) u_dut (
    .CLK(clk), .CLR_N(clr_n), .CTEN_N(cten_n), .D_U(d_u), .LOAD_N(load_n),
    .D(d), .Q(q), .MAX_MIN(max_min), .RCO_N(rco_n)
  );

  mod_74x191_clr #(.WIDTH(4)) u_stage1 (
    .CLK(clk), .CLR_N(c_clr_n), .CTEN_N(1'b0), .D_U(1'b0), .LOAD_N(1'b1),
    .D(4'd0), .Q(q1), .MAX_MIN(max1), .RCO_N(rco1)
  );

  mod_74x191_clr #(.WIDTH(4)) u_stage2 (
    .CLK(rco1), .CLR_N(c_clr_n), .CTEN_N(1'b0), .D_U(1'b0), .LOAD_N(1'b1),
    .D(4'd0), .Q(q2), .MAX_MIN(max2), .RCO_N(rco2)
  );

  task automatic test_reset();
    @(negedge clk); #1;
    d_u = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("[TB] FAIL reset_q got %0d expected 0", q); end
    checks++;
    if (max_min !== 1'b0) begin errors++; $display("[TB] FAIL reset_maxmin_up got %b expected 0", max_min); end
    d_u = 1'b1;
    #1;
    checks++;
    if (max_min !== 1'b1) begin errors++; $display("[TB] FAIL reset_maxmin_dn got %b expected 1", max_min); end
    checks++;
    if (rco_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_rco got %b expected 0", rco_n); end
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("[TB] FAIL reset_hold_q got %0d expected 0", q); end
  endtask

  task automatic test_async_clear();
    @(negedge clk);
    clr_n = 1'b1; load_n = 1'b0; cten_n = 1'b1; d_u = 1'b0; d = 4'd9;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd9) begin errors++; $display("[TB] FAIL clr_preload got %0d expected 9", q); end
    #2;
    load_n = 1'b1; cten_n = 1'b0;
    clr_n = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0) begin errors++; $display("[TB] FAIL clr_async got %0d expected 0", q); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== 4'd0) begin errors++; $display("[TB] FAIL clr_held edge=%0d got %0d expected 0", i, q); end
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd1) begin errors++; $display("[TB] FAIL clr_release got %0d expected 1", q); end
  endtask

  task automatic test_up_count();
    logic [3:0] exp_q;
    @(negedge clk);
    clr_n = 1'b0; #1; clr_n = 1'b1;
    d_u = 1'b0; cten_n = 1'b0; load_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      exp_q = 4'(i % 16);
      @(posedge clk); #1;
      checks++;
      if (q !== exp_q) begin errors++; $display("[TB] FAIL up_q i=%0d got %0d expected %0d", i, q, exp_q); end
      checks++;
      if (max_min !== (exp_q == 4'd15)) begin errors++; $display("[TB] FAIL up_maxmin i=%0d got %b expected %b", i, max_min, exp_q == 4'd15); end
      checks++;
      if (rco_n !== 1'b1) begin errors++; $display("[TB] FAIL up_rco_clkhigh i=%0d got %b expected 1", i, rco_n); end
      @(negedge clk); #1;
      checks++;
      if (rco_n !== (exp_q != 4'd15)) begin errors++; $display("[TB] FAIL up_rco_clklow i=%0d got %b expected %b", i, rco_n, exp_q != 4'd15); end
    end
  endtask

  task automatic test_down_count();
    logic [3:0] exp_tbl [4];
    exp_tbl = '{4'd1, 4'd0, 4'd15, 4'd14};
    @(negedge clk);
    load_n = 1'b0; d = 4'd2; d_u = 1'b1; cten_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd2) begin errors++; $display("[TB] FAIL dn_load got %0d expected 2", q); end
    @(negedge clk);
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q !== exp_tbl[i]) begin errors++; $display("[TB] FAIL dn_q i=%0d got %0d expected %0d", i, q, exp_tbl[i]); end
      checks++;
      if (max_min !== (exp_tbl[i] == 4'd0)) begin errors++; $display("[TB] FAIL dn_maxmin i=%0d got %b expected %b", i, max_min, exp_tbl[i] == 4'd0); end
    end
  endtask

  task automatic test_load_priority();
    @(negedge clk);
    load_n = 1'b0; cten_n = 1'b1; d_u = 1'b0; d = 4'd11;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd11) begin errors++; $display("[TB] FAIL load_a got %0d expected 11", q); end
    @(negedge clk);
    cten_n = 1'b0; d = 4'd5;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd5) begin errors++; $display("[TB] FAIL load_over_count got %0d expected 5", q); end
    @(negedge clk);
    load_n = 1'b1; cten_n = 1'b1; d = 4'bxxxx;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd5) begin errors++; $display("[TB] FAIL load_d_ignored got %0d expected 5", q); end
  endtask

  task automatic test_enable_toggle();
    @(negedge clk);
    load_n = 1'b0; d = 4'd15; cten_n = 1'b1; d_u = 1'b0;
    @(posedge clk); #1;
    load_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (max_min !== 1'b1) begin errors++; $display("[TB] FAIL en_maxmin i=%0d got %b expected 1", i, max_min); end
      checks++;
      if (rco_n !== 1'b1) begin errors++; $display("[TB] FAIL en_rco i=%0d got %b expected 1", i, rco_n); end
      @(posedge clk); #1;
      checks++;
      if (q !== 4'd15) begin errors++; $display("[TB] FAIL en_hold i=%0d got %0d expected 15", i, q); end
    end
    #1;
    d_u = 1'b1;
    #1;
    checks++;
    if (max_min !== 1'b0) begin errors++; $display("[TB] FAIL dir_maxmin got %b expected 0", max_min); end
    checks++;
    if (q !== 4'd15) begin errors++; $display("[TB] FAIL dir_q got %0d expected 15", q); end
    cten_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q !== 4'd14) begin errors++; $display("[TB] FAIL dir_count got %0d expected 14", q); end
  endtask

  task automatic test_cascade();
    @(negedge clk);
    c_clr_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (q1 !== 4'd8) begin errors++; $display("[TB] FAIL cascade_s1 got %0d expected 8", q1); end
    checks++;
    if (q2 !== 4'd2) begin errors++; $display("[TB] FAIL cascade_s2 got %0d expected 2", q2); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    clr_n = 1'b0; c_clr_n = 1'b0;
    cten_n = 1'b0; d_u = 1'b0; load_n = 1'b1; d = 4'd0;
    test_reset();
    test_async_clear();
    test_up_count();
    test_down_count();
    test_load_priority();
    test_enable_toggle();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
